event_pulse_stretcher: RTL and testbench

//   Output-side counterpart of the button debouncer: turns single-cycle internal event pulses
//   (FIFO write accepted, full, empty, ...) into human-visible LED blinks on the board.

---
 rtl/fifo_ui_pkg.sv | 22 ++
 rtl/stretch_timer.sv | 30 +++
 rtl/event_pulse_stretcher.sv | 150 +++++++++++++++
 tb/tb_event_pulse_stretcher.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ui_pkg.sv
// Shared definitions for the board user-interface blocks (LED stretchers,
// debouncers): FSM state encodings, board clock rate and default blink/gap times.
package fifo_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } ui_state_e;

    localparam int CLK_HZ               = 50_000_000;
    localparam int DEFAULT_BLINK_CYCLES = 2_500_000;   // 50 ms at CLK_HZ
    localparam int DEFAULT_GAP_CYCLES   = 2_500_000;   // 50 ms at CLK_HZ
    localparam int DEFAULT_CNT_WIDTH    = 22;
    localparam int DEFAULT_PEND_WIDTH   = 4;

    // Convert a duration in milliseconds to board clock cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/stretch_timer.sv
// Loadable down-counter shared by the board UI blocks. A load takes priority;
// otherwise the count decrements and parks at zero. zero_o flags count == 0.
module stretch_timer #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_q;

    // Count register: load on request, otherwise count down to zero and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/event_pulse_stretcher.sv
// Turns single-cycle event strobes into LED blinks of fixed on-time, each followed
// by a fixed dark gap. Events arriving mid-blink are queued in a saturating counter.
// Optional feature: define PULSE_STRETCH_OVF_EN to get a sticky overflow flag that
// records any event dropped because the queue was full; otherwise overflow is 0.
//
//   state | meaning
//   IDLE  | LED dark, nothing queued, waiting for an event
//   ON    | LED lit, timer counting the on-time
//   OFF   | LED dark, timer counting the mandatory gap before the next blink
module event_pulse_stretcher
    import fifo_ui_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_BLINK_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int PEND_WIDTH = DEFAULT_PEND_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  event_pulse,
    output logic                  led_out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    localparam logic [CNT_WIDTH-1:0]  ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  OFF_LOAD = CNT_WIDTH'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    ui_state_e             state_q, state_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  led_q, led_d;
    logic                  busy_q, busy_d;

    logic                  tmr_load;
    logic [CNT_WIDTH-1:0]  tmr_value;
    logic                  tmr_zero;

    logic                  have_event;
    logic                  take;
    logic                  take_pend;
    logic                  accept;
    logic                  drop;

    stretch_timer #(
        .W (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // State, queue and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // Next state and timer reload; a "take" starts a blink and consumes one event.
    always_comb begin
        have_event = (pend_q != '0) || event_pulse;
        state_d    = state_q;
        take       = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = ON_LOAD;
        case (state_q)
            ST_IDLE: begin
                if (have_event) begin
                    state_d  = ST_ON;
                    take     = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            ST_ON: begin
                if (tmr_zero) begin
                    state_d   = ST_OFF;
                    tmr_load  = 1'b1;
                    tmr_value = OFF_LOAD;
                end
            end
            ST_OFF: begin
                if (tmr_zero) begin
                    if (have_event) begin
                        state_d  = ST_ON;
                        take     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending queue: queued events are consumed before a same-cycle strobe, and a
    // strobe that finds the queue full with nothing leaving is dropped.
    always_comb begin
        take_pend = take && (pend_q != '0);
        accept    = event_pulse && !(take && (pend_q == '0));
        drop      = accept && !take_pend && (pend_q == PEND_MAX);
        pend_d    = pend_q;
        if (take_pend && !accept) begin
            pend_d = pend_q - PEND_ONE;
        end else if (accept && !take_pend && !drop) begin
            pend_d = pend_q + PEND_ONE;
        end
    end

    // Registered outputs follow the upcoming state.
    always_comb begin
        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign pending = pend_q;

`ifdef PULSE_STRETCH_OVF_EN
    logic ovf_q;

    // Sticky record of any dropped event; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_event_pulse_stretcher.sv
module tb_event_pulse_stretcher;

    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int P   = ON + OFF;

`ifdef PULSE_STRETCH_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       event_pulse = 1'b0;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_pass = 0;
    int n_total = 0;

    exp_t sb[$];

    event_pulse_stretcher #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_WIDTH  (3),
        .PEND_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_pulse (event_pulse),
        .led_out     (led_out),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Evenly spaced blinks starting at cycle 0: LED high for the first ON cycles of each period.
    function automatic logic exp_led(input int nblink, input int k);
        return (k < nblink * P) && ((k % P) < ON);
    endfunction

    function automatic logic exp_busy(input int nblink, input int k);
        return (k < nblink * P);
    endfunction

    task automatic do_reset();
        event_pulse = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            event_pulse = k[0];
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== 5'b0) $display("FAIL reset_hold cycle %0d got %b exp %b", k, got, 5'b0);
            else n_pass++;
        end
        event_pulse = 1'b0;
        rst = 1'b0;
        event_pulse = 1'b1;
        @(posedge clk); #1;
        event_pulse = 1'b0;
        n_total++;
        if (led_out !== 1'b1 || busy !== 1'b1) $display("FAIL reset_pre_led got led=%b busy=%b exp led=1 busy=1", led_out, busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        got = {led_out, busy, pending, overflow};
        n_total++;
        if (got !== 5'b0) $display("FAIL reset_async got %b exp %b", got, 5'b0);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        exp_t e;
        logic [4:0] got;
        for (int k = 0; k < 10; k++) sb.push_back('{exp_led(1, k), exp_busy(1, k), 2'd0, 1'b0});
        for (int k = 0; k < 10; k++) begin
            event_pulse = (k == 0);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== e) $display("FAIL single cycle %0d got %b exp %b", k, got, e);
            else n_pass++;
        end
        event_pulse = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [4:0] got;
        logic [1:0] p;
        for (int k = 0; k < 23; k++) begin
            p = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 7) ? 2'd2 : (k < 14) ? 2'd1 : 2'd0;
            sb.push_back('{exp_led(3, k), exp_busy(3, k), p, 1'b0});
        end
        for (int k = 0; k < 23; k++) begin
            event_pulse = (k < 3);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== e) $display("FAIL back_to_back cycle %0d got %b exp %b", k, got, e);
            else n_pass++;
        end
        event_pulse = 1'b0;
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [4:0] got;
        logic [1:0] p;
        for (int k = 0; k < 30; k++) begin
            p = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k == 2) ? 2'd2 :
                (k < 7) ? 2'd3 : (k < 14) ? 2'd2 : (k < 21) ? 2'd1 : 2'd0;
            sb.push_back('{exp_led(4, k), exp_busy(4, k), p, (k >= 4) ? OVF_ON : 1'b0});
        end
        for (int k = 0; k < 30; k++) begin
            event_pulse = (k < 6);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== e) $display("FAIL saturate cycle %0d got %b exp %b", k, got, e);
            else n_pass++;
        end
        event_pulse = 1'b0;
    endtask

    task automatic test_timeout_event();
        exp_t e;
        logic [4:0] got;
        logic [1:0] p;
        for (int k = 0; k < 30; k++) begin
            p = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k < 14) ? 2'd2 : (k < 21) ? 2'd1 : 2'd0;
            sb.push_back('{exp_led(4, k), exp_busy(4, k), p, 1'b0});
        end
        for (int k = 0; k < 30; k++) begin
            event_pulse = (k < 3) || (k == P);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== e) $display("FAIL timeout_event cycle %0d got %b exp %b", k, got, e);
            else n_pass++;
        end
        event_pulse = 1'b0;
    endtask

    task automatic test_reset_mid_blink();
        exp_t e;
        logic [4:0] got;
        logic [1:0] p;
        for (int k = 0; k < 9; k++) begin
            p = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k == 2) ? 2'd2 : (k < 7) ? 2'd3 : 2'd2;
            sb.push_back('{exp_led(4, k), exp_busy(4, k), p, (k >= 4) ? OVF_ON : 1'b0});
        end
        for (int k = 0; k < 9; k++) begin
            event_pulse = (k < 6);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== e) $display("FAIL mid_blink_pre cycle %0d got %b exp %b", k, got, e);
            else n_pass++;
        end
        event_pulse = 1'b0;
        #2 rst = 1'b1;
        #1;
        got = {led_out, busy, pending, overflow};
        n_total++;
        if (got !== 5'b0) $display("FAIL mid_blink_async got %b exp %b", got, 5'b0);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            got = {led_out, busy, pending, overflow};
            n_total++;
            if (got !== 5'b0) $display("FAIL mid_blink_after cycle %0d got %b exp %b", k, got, 5'b0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        do_reset();
        test_back_to_back();
        do_reset();
        test_saturate();
        do_reset();
        test_timeout_event();
        do_reset();
        test_reset_mid_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
